// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter and access sequencer for the shared memory port
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  sel,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic [3:0] lat_cnt;
    logic       grant_vld;
    logic       grant_id;

    // On a tie the master that did not win last time gets the port.
    always_comb begin
        grant_vld = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = mem_we ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_en = (state == S_ISSUE);
        ack0   = (state == S_ACK) && !sel;
        ack1   = (state == S_ACK) && sel;
        busy   = (state != S_IDLE);
    end

    // Grant-time capture: command fields stay frozen until the port returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 1'b0;
            last_grant <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (state == S_IDLE && grant_vld) begin
            sel        <= grant_id;
            last_grant <= grant_id;
            mem_we     <= grant_id ? we1 : we0;
            mem_addr   <= grant_id ? addr1 : addr0;
            mem_wdata  <= grant_id ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= 4'd0;
            rdata   <= '0;
        end else begin
            case (state)
                S_ISSUE: begin
                    if (!mem_we) begin
                        lat_cnt <= LAT_INIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        rdata <= mem_rdata;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at read latencies 1 and 4
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Instance a: RD_LATENCY=1
    logic       a_req0, a_we0, a_req1, a_we1;
    logic [5:0] a_addr0, a_addr1;
    logic [7:0] a_wdata0, a_wdata1;
    logic       a_ack0, a_ack1, a_sel, a_mem_en, a_mem_we, a_busy;
    logic [7:0] a_rdata, a_mem_wdata, a_mem_rdata;
    logic [5:0] a_mem_addr;

    // Instance b: RD_LATENCY=4
    logic       b_req0, b_we0, b_req1, b_we1;
    logic [5:0] b_addr0, b_addr1;
    logic [7:0] b_wdata0, b_wdata1;
    logic       b_ack0, b_ack1, b_sel, b_mem_en, b_mem_we, b_busy;
    logic [7:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic [5:0] b_mem_addr;

    mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0),
        .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1),
        .ack0(a_ack0), .ack1(a_ack1), .rdata(a_rdata), .sel(a_sel),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RD_LATENCY(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .sel(b_sel),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: read data is only meaningful in the cycle the latency says; 0xEE otherwise.
    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    logic       pa_v;
    logic [7:0] pa_d;
    logic [3:0] pb_v;
    logic [7:0] pb_d [4];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        mem_a[6'h3F] = 8'h5C;
        mem_b[6'h0A] = 8'h96;
        pa_v = 1'b0;
        pb_v = 4'b0000;
    end

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
        pa_v <= a_mem_en && !a_mem_we;
        pa_d <= mem_a[a_mem_addr];
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        pb_v <= {pb_v[2:0], b_mem_en && !b_mem_we};
        pb_d[0] <= mem_b[b_mem_addr];
        pb_d[1] <= pb_d[0];
        pb_d[2] <= pb_d[1];
        pb_d[3] <= pb_d[2];
    end

    assign a_mem_rdata = pa_v ? pa_d : 8'hEE;
    assign b_mem_rdata = pb_v[3] ? pb_d[3] : 8'hEE;

    typedef struct {
        int         master;
        int         cyc;
        logic [7:0] rdata;
    } exp_t;

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [7:0] exp_rd_a;
    logic [7:0] exp_rd_b;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic exp_t mk(input int m, input int c, input logic [7:0] d);
        exp_t e;
        e.master = m;
        e.cyc    = c;
        e.rdata  = d;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (a_ack0 || a_ack1) begin
            chk("a_ack_exclusive", int'(a_ack0 && a_ack1), 0);
            chk("a_ack_vs_mem_en", int'(a_mem_en), 0);
            if (q_a.size() == 0) begin
                chk("a_unexpected_ack", 1, 0);
            end else begin
                e = q_a.pop_front();
                chk("a_ack_master", int'(a_ack1), e.master);
                chk("a_ack_cycle", cyc, e.cyc);
                chk("a_ack_rdata", int'(a_rdata), int'(e.rdata));
            end
        end
        if (b_ack0 || b_ack1) begin
            chk("b_ack_exclusive", int'(b_ack0 && b_ack1), 0);
            chk("b_ack_vs_mem_en", int'(b_mem_en), 0);
            if (q_b.size() == 0) begin
                chk("b_unexpected_ack", 1, 0);
            end else begin
                e = q_b.pop_front();
                chk("b_ack_master", int'(b_ack1), e.master);
                chk("b_ack_cycle", cyc, e.cyc);
                chk("b_ack_rdata", int'(b_rdata), int'(e.rdata));
            end
        end
    end

    task automatic chk_a_reset_outputs(input string tag);
        chk({tag, "_ack0"}, int'(a_ack0), 0);
        chk({tag, "_ack1"}, int'(a_ack1), 0);
        chk({tag, "_mem_en"}, int'(a_mem_en), 0);
        chk({tag, "_mem_we"}, int'(a_mem_we), 0);
        chk({tag, "_mem_addr"}, int'(a_mem_addr), 0);
        chk({tag, "_mem_wdata"}, int'(a_mem_wdata), 0);
        chk({tag, "_rdata"}, int'(a_rdata), 0);
        chk({tag, "_busy"}, int'(a_busy), 0);
        chk({tag, "_sel"}, int'(a_sel), 0);
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        {a_req0, a_we0, a_req1, a_we1} = 4'b0;
        {b_req0, b_we0, b_req1, b_we1} = 4'b0;
        a_addr0 = '0; a_addr1 = '0; a_wdata0 = '0; a_wdata1 = '0;
        b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
        exp_rd_a = 8'h00;
        exp_rd_b = 8'h00;
        repeat (2) @(negedge clk);
        chk_a_reset_outputs("reset");
        chk("reset_b_busy", int'(b_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both masters held high out of reset: 0,1,0,1 with one write every 3 cycles
        a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 6'h01; a_wdata0 = 8'h11;
        a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 6'h02; a_wdata1 = 8'h22;
        g = cyc + 1;
        for (int k = 0; k < 4; k++) q_a.push_back(mk(k % 2, g + 3 * k + 1, exp_rd_a));
        for (int k = 0; k < 4; k++) begin
            wait_cyc(g + 3 * k);
            chk("rr_sel", int'(a_sel), k % 2);
            chk("rr_mem_en", int'(a_mem_en), 1);
        end
        wait_cyc(g + 10);
        a_req0 = 1'b0; a_req1 = 1'b0;
        wait_cyc(g + 12);

        // Single write from master 0
        a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 6'h15; a_wdata0 = 8'hA5;
        g = cyc + 1;
        q_a.push_back(mk(0, g + 1, exp_rd_a));
        wait_cyc(g);
        chk("wr_mem_en", int'(a_mem_en), 1);
        chk("wr_mem_we", int'(a_mem_we), 1);
        chk("wr_mem_addr", int'(a_mem_addr), 'h15);
        chk("wr_mem_wdata", int'(a_mem_wdata), 'hA5);
        chk("wr_sel", int'(a_sel), 0);
        wait_cyc(g + 1);
        chk("wr_ack1_low", int'(a_ack1), 0);
        a_req0 = 1'b0;
        wait_cyc(g + 3);

        // Single read from master 1, latency 1
        a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 6'h3F;
        g = cyc + 1;
        exp_rd_a = 8'h5C;
        q_a.push_back(mk(1, g + 2, exp_rd_a));
        wait_cyc(g);
        chk("rd_sel", int'(a_sel), 1);
        chk("rd_mem_en", int'(a_mem_en), 1);
        chk("rd_mem_we", int'(a_mem_we), 0);
        chk("rd_mem_addr", int'(a_mem_addr), 'h3F);
        wait_cyc(g + 1);
        chk("rd_wait_mem_en", int'(a_mem_en), 0);
        chk("rd_wait_sel", int'(a_sel), 1);
        wait_cyc(g + 2);
        a_req1 = 1'b0;
        wait_cyc(g + 4);

        // Reset while a read is in WAIT: outputs clear at once, no ack ever follows
        a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 6'h05;
        g = cyc + 1;
        wait_cyc(g + 1);
        chk("abort_busy_before", int'(a_busy), 1);
        a_req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_a_reset_outputs("abort");
        exp_rd_a = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_busy_after", int'(a_busy), 0);
        chk("abort_sel_after", int'(a_sel), 0);

        // Master 0 read in flight; req1 rises and addr0 changes during WAIT
        a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 6'h3F;
        g = cyc + 1;
        exp_rd_a = 8'h5C;
        q_a.push_back(mk(0, g + 2, exp_rd_a));
        wait_cyc(g + 1);
        a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 6'h02; a_addr0 = 6'h00;
        exp_rd_a = 8'h22;
        q_a.push_back(mk(1, g + 6, exp_rd_a));
        chk("midchg_addr_wait", int'(a_mem_addr), 'h3F);
        wait_cyc(g + 2);
        chk("midchg_addr_ack", int'(a_mem_addr), 'h3F);
        a_req0 = 1'b0;
        wait_cyc(g + 4);
        chk("midchg_m1_sel", int'(a_sel), 1);
        chk("midchg_m1_mem_en", int'(a_mem_en), 1);
        chk("midchg_m1_addr", int'(a_mem_addr), 'h02);
        wait_cyc(g + 6);
        a_req1 = 1'b0;
        wait_cyc(g + 8);

        // Latency 4 read, then a write that must leave rdata alone
        b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 6'h0A;
        g = cyc + 1;
        exp_rd_b = 8'h96;
        q_b.push_back(mk(0, g + 5, exp_rd_b));
        wait_cyc(g + 4);
        chk("lat4_no_early_ack", int'(b_ack0), 0);
        chk("lat4_busy", int'(b_busy), 1);
        wait_cyc(g + 5);
        b_req0 = 1'b0;
        wait_cyc(g + 7);
        b_req1 = 1'b1; b_we1 = 1'b1; b_addr1 = 6'h0B; b_wdata1 = 8'h77;
        g = cyc + 1;
        q_b.push_back(mk(1, g + 1, exp_rd_b));
        wait_cyc(g + 1);
        b_req1 = 1'b0;
        wait_cyc(g + 3);
        chk("lat4_rdata_after_write", int'(b_rdata), 'h96);

        chk("a_pending_acks", q_a.size(), 0);
        chk("b_pending_acks", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
